slow_mem_arbiter: RTL

- Shares one slow_memory port between the instruction-side and data-side cache miss paths, so CHIP needs one external 128-bit line memory instead of two.
- Sits between the I-cache/D-cache memory-side ports and the single slow_memory instance.
- Grants one requester at a time and holds the grant until the transaction completes.
- Forwards mem_ready only to the owner, then inserts a one-cycle release gap before re-arbitrating.

---
 rtl/slow_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/slow_mem_arbiter.sv
// Shares one slow line memory between the I-side and D-side miss paths; one owner at a time, one-cycle release gap.
// Optional ARB_RR_EN: simultaneous requests alternate against last_owner instead of the fixed D_FIRST priority.
module slow_mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter bit D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [1:0]        state_o,
  output logic              last_owner_o
);

  // Handshake: a side requests while x_read|x_write is high and holds addr/data/strobes
  // until x_ready (a one-cycle pulse); it drops the strobe on the following cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;  // 1: D side held the most recent grant
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              req_i, req_d, pick_d;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

`ifdef ARB_RR_EN
  assign pick_d = ~last_d_q;
`else
  assign pick_d = D_FIRST;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d  = pick_d ? GRANT_D : GRANT_I;
          last_d_d = pick_d;
        end else if (req_d) begin
          state_d  = GRANT_D;
          last_d_d = 1'b1;
        end else if (req_i) begin
          state_d  = GRANT_I;
          last_d_d = 1'b0;
        end
      end
      // A write wins over a simultaneous read; a dropped request aborts without a ready pulse.
      GRANT_I: begin
        mem_read  = i_read & ~i_write;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_rdata   = mem_rdata;
        if (!req_i) begin
          state_d = RELEASE;
        end else if (mem_ready) begin
          i_ready   = 1'b1;
          i_rdata_d = mem_rdata;
          state_d   = RELEASE;
        end
      end
      GRANT_D: begin
        mem_read  = d_read & ~d_write;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_rdata   = mem_rdata;
        if (!req_d) begin
          state_d = RELEASE;
        end else if (mem_ready) begin
          d_ready   = 1'b1;
          d_rdata_d = mem_rdata;
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign state_o      = state_q;
  assign last_owner_o = last_d_q;

endmodule
